// File: rtl/pipe_adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined N-operand adder tree.
package pipe_adder_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  // Operands produced by one tree level from n inputs (odd leftover passes through).
  function automatic int unsigned half_up(input int unsigned n);
    return (n + 1) / 2;
  endfunction

  function automatic int unsigned ops_at_level(input int unsigned n, input int unsigned k);
    int unsigned c;
    c = n;
    for (int unsigned i = 0; i < k; i++) c = half_up(c);
    return c;
  endfunction

  // Bit offset of level k inside the flat inter-level data bus (level 0 = raw operands).
  function automatic int unsigned bus_off(input int unsigned n, input int unsigned w,
                                          input int unsigned k);
    int unsigned off;
    off = 0;
    for (int unsigned i = 0; i < k; i++) off += ops_at_level(n, i) * (w + i);
    return off;
  endfunction

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_NUM_OPS = 3;
  localparam int unsigned LEVELS      = clog2(DEF_NUM_OPS);
  localparam int unsigned SUM_W       = DEF_WIDTH + LEVELS;

endpackage

// File: rtl/pipe_adder_stage.sv
// One adder-tree level: pairwise sums of IN_CNT operands plus a valid/tag register.
module pipe_adder_stage
  import pipe_adder_pkg::*;
#(
  parameter int unsigned IN_CNT = 3,
  parameter int unsigned IN_W   = 8,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [IN_CNT*IN_W-1:0]               in_data,
  input  logic [TAG_W-1:0]                     in_tag,
  input  logic                                 in_valid,
  input  logic                                 ready,
  output logic [half_up(IN_CNT)*(IN_W+1)-1:0]  out_data,
  output logic [TAG_W-1:0]                     out_tag,
  output logic                                 out_valid
);

  localparam int unsigned OUT_CNT = half_up(IN_CNT);
  localparam int unsigned OW      = IN_W + 1;

  logic [OUT_CNT*OW-1:0] sum;

  for (genvar j = 0; j < OUT_CNT; j++) begin : g_pair
    if (2 * j + 1 < IN_CNT) begin : g_add
      assign sum[j*OW +: OW] = OW'(in_data[2*j*IN_W +: IN_W])
                             + OW'(in_data[(2*j+1)*IN_W +: IN_W]);
    end else begin : g_pass
      assign sum[j*OW +: OW] = OW'(in_data[2*j*IN_W +: IN_W]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= sum;
        out_tag  <= in_tag;
      end
    end
  end

endmodule

// File: rtl/pipe_adder_n.sv
// Pipelined NUM_OPS-operand adder with req/ack flow control and tag sideband.
// Define PIPE_ADDER_SAT_EN to saturate (and flag ovf) instead of wrapping to OUT_W.
module pipe_adder_n
  import pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_OPS = 3,
  parameter int unsigned OUT_W   = WIDTH + clog2(NUM_OPS),
  parameter int unsigned TAG_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_OPS*WIDTH-1:0] ops,
  input  logic [TAG_W-1:0]         tag_in,
  input  logic                     Rin,
  output logic                     Ain,
  output logic [OUT_W-1:0]         out,
  output logic [TAG_W-1:0]         tag_out,
  output logic                     ovf,
  output logic                     Rout,
  input  logic                     Aout
);

  localparam int unsigned LV     = clog2(NUM_OPS);
  localparam int unsigned FULL_W = WIDTH + LV;
  localparam int unsigned BUS_W  = bus_off(NUM_OPS, WIDTH, LV) + FULL_W;

  logic             live;
  logic [LV:0]      v;
  logic [LV:0]      rdy;
  logic [TAG_W-1:0] tg [0:LV];
  logic [BUS_W-1:0] bus;
  logic [FULL_W-1:0] full;

  // Holds Ain low until the first clock edge after reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) live <= 1'b0;
    else     live <= 1'b1;
  end

  assign v[0]                   = Rin & live;
  assign tg[0]                  = tag_in;
  assign bus[0 +: NUM_OPS*WIDTH] = ops;

  // Ready ripples backwards from the consumer: a stage may load if empty or draining.
  always_comb begin
    rdy     = '0;
    rdy[LV] = Aout;
    for (int unsigned i = 0; i < LV; i++) rdy[LV-1-i] = ~v[LV-i] | rdy[LV-i];
  end

  for (genvar k = 0; k < LV; k++) begin : g_lvl
    localparam int unsigned CNT   = ops_at_level(NUM_OPS, k);
    localparam int unsigned IW    = WIDTH + k;
    localparam int unsigned OFF_I = bus_off(NUM_OPS, WIDTH, k);
    localparam int unsigned OFF_O = bus_off(NUM_OPS, WIDTH, k + 1);

    pipe_adder_stage #(
      .IN_CNT (CNT),
      .IN_W   (IW),
      .TAG_W  (TAG_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_data   (bus[OFF_I +: CNT*IW]),
      .in_tag    (tg[k]),
      .in_valid  (v[k]),
      .ready     (rdy[k]),
      .out_data  (bus[OFF_O +: half_up(CNT)*(IW+1)]),
      .out_tag   (tg[k+1]),
      .out_valid (v[k+1])
    );
  end

  assign Ain     = rdy[0] & live;
  assign Rout    = v[LV];
  assign tag_out = tg[LV];
  assign full    = bus[BUS_W-FULL_W +: FULL_W];

`ifdef PIPE_ADDER_SAT_EN
  localparam int unsigned CW = ((FULL_W > OUT_W) ? FULL_W : OUT_W) + 1;
  localparam logic [CW-1:0] MAXV = (CW'(1) << OUT_W) - CW'(1);

  always_comb begin
    out = OUT_W'(CW'(full));
    ovf = 1'b0;
    if (CW'(full) > MAXV) begin
      out = '1;
      ovf = 1'b1;
    end
  end
`else
  assign out = OUT_W'(full);
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_adder_n.sv
// Randomised and directed bench for pipe_adder_n against a queue-based reference model.
module tb_pipe_adder_n;

  logic        clk, rst;
  // default configuration: WIDTH=8, NUM_OPS=3, OUT_W=10
  logic [23:0] ops;
  logic [3:0]  tag_in, tag_out;
  logic        Rin, Ain, ovf, Rout, Aout;
  logic [9:0]  out;
  // narrow output: OUT_W=8
  logic [23:0] n_ops;
  logic [3:0]  n_tag, n_tago;
  logic        n_Rin, n_Ain, n_ovf, n_Rout, n_Aout;
  logic [7:0]  n_out;
  // five operands of 4 bits
  logic [19:0] f_ops;
  logic [3:0]  f_tag, f_tago;
  logic        f_Rin, f_Ain, f_ovf, f_Rout, f_Aout;
  logic [6:0]  f_out;

  pipe_adder_n dut (
    .clk(clk), .rst(rst), .ops(ops), .tag_in(tag_in), .Rin(Rin), .Ain(Ain),
    .out(out), .tag_out(tag_out), .ovf(ovf), .Rout(Rout), .Aout(Aout)
  );

  pipe_adder_n #(.WIDTH(8), .NUM_OPS(3), .OUT_W(8)) dut_n (
    .clk(clk), .rst(rst), .ops(n_ops), .tag_in(n_tag), .Rin(n_Rin), .Ain(n_Ain),
    .out(n_out), .tag_out(n_tago), .ovf(n_ovf), .Rout(n_Rout), .Aout(n_Aout)
  );

  pipe_adder_n #(.WIDTH(4), .NUM_OPS(5)) dut_f (
    .clk(clk), .rst(rst), .ops(f_ops), .tag_in(f_tag), .Rin(f_Rin), .Ain(f_Ain),
    .out(f_out), .tag_out(f_tago), .ovf(f_ovf), .Rout(f_Rout), .Aout(f_Aout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks, errors;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic longint sum_ops(input logic [63:0] v, input int unsigned n,
                                     input int unsigned w);
    longint s;
    s = 0;
    for (int unsigned i = 0; i < n; i++) s += longint'((v >> (w * i)) & ((64'd1 << w) - 1));
    return s;
  endfunction

  function automatic void model_res(input longint s, input int unsigned w,
                                    output longint eo, output longint eovf);
    longint maxv;
    maxv = (longint'(1) << w) - 1;
`ifdef PIPE_ADDER_SAT_EN
    if (s > maxv) begin eo = maxv; eovf = 1; end
    else          begin eo = s;    eovf = 0; end
`else
    eo   = s & maxv;
    eovf = 0;
`endif
  endfunction

  typedef struct { longint sum; longint tag; } exp_t;
  exp_t        q[$];
  bit          in_x, out_x, was_stall;
  logic [9:0]  hold_out;
  logic [3:0]  hold_tag;
  int unsigned n_in, n_res;

  // Called at posedge+1; samples handshake at posedge+2, then advances one clock.
  task automatic cycle();
    exp_t   e;
    longint eo, eovf;
    #1;
    in_x  = Rin && Ain;
    out_x = Rout && Aout;
    if (Rout && was_stall) begin
      check("hold_out", out, hold_out);
      check("hold_tag", tag_out, hold_tag);
    end
    was_stall = Rout && !Aout;
    hold_out  = out;
    hold_tag  = tag_out;
    if (out_x) begin
      if (q.size() == 0) check("extra_result", 1, 0);
      else begin
        e = q.pop_front();
        model_res(e.sum, 10, eo, eovf);
        check("out", out, eo);
        check("tag", tag_out, e.tag);
        check("ovf", ovf, eovf);
        n_res++;
      end
    end
    if (in_x) begin
      q.push_back('{sum_ops(64'(ops), 3, 8), longint'(tag_in)});
      n_in++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned lat, idx, cyc, acc;
    longint      eo, eovf;
    checks = 0; errors = 0; n_in = 0; n_res = 0; was_stall = 0;
    rst = 1'b1; Rin = 0; Aout = 0; ops = '0; tag_in = '0;
    n_Rin = 0; n_Aout = 0; n_ops = '0; n_tag = '0;
    f_Rin = 0; f_Aout = 0; f_ops = '0; f_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rout", Rout, 0);
    check("rst_ain", Ain, 0);
    check("rst_out", out, 0);
    check("rst_tag", tag_out, 0);
    check("rst_ovf", ovf, 0);
    check("rst_other_rout", {n_Rout, f_Rout}, 0);

    // first transaction after reset release
    ops = {8'd4, 8'd4, 8'd4}; tag_in = 4'd5; Rin = 1; Aout = 1;
    rst = 1'b0;
    #1 check("ain_before_edge", Ain, 0);
    @(posedge clk); #1;
    check("ain_rise", Ain, 1);
    @(posedge clk); #1;
    Rin = 0;
    lat = 1;
    while (!Rout && lat < 10) begin @(posedge clk); #1; lat++; end
    check("latency3op", lat, 2);
    check("first_out", out, 12);
    check("first_tag", tag_out, 5);
    @(posedge clk); #1;

    // reset while a result is waiting on the output
    Aout = 0; Rin = 1; ops = 24'($urandom); tag_in = 4'd9;
    @(posedge clk); #1;
    Rin = 0;
    lat = 0;
    while (!Rout && lat < 10) begin @(posedge clk); #1; lat++; end
    check("midflight_rout_pre", Rout, 1);
    #2 rst = 1'b1;
    #1;
    check("midflight_rout", Rout, 0);
    check("midflight_out", out, 0);
    check("midflight_ain", Ain, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // exhaustive 0..4 sweep streamed back-to-back
    Aout = 1; idx = 0; cyc = 0;
    while (idx < 125 && cyc < 400) begin
      ops    = {8'(idx % 5), 8'((idx / 5) % 5), 8'(idx / 25)};
      tag_in = 4'(idx % 16);
      Rin    = 1;
      cycle();
      cyc++;
      if (in_x) idx++;
    end
    check("sweep_cycles", cyc, 125);
    Rin = 0;
    repeat (6) cycle();
    check("sweep_drain", q.size(), 0);
    check("sweep_count", n_res, 125);

    // back-pressure: consumer stalls for six cycles
    Aout = 0; Rin = 1; acc = 0;
    ops = 24'($urandom); tag_in = 4'($urandom);
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (in_x) begin acc++; ops = 24'($urandom); tag_in = 4'($urandom); end
    end
    check("bp_accepted", acc, 2);
    #1 check("bp_ain_low", Ain, 0);
    Rin = 0; Aout = 1;
    repeat (5) cycle();
    check("bp_drain", q.size(), 0);

    // maximum operands
    ops = {3{8'hFF}}; tag_in = 4'd7; Rin = 1;
    cyc = 0;
    while (cyc < 10) begin cycle(); cyc++; if (in_x) break; end
    Rin = 0;
    repeat (4) cycle();
    check("max_drain", q.size(), 0);

    // random traffic with random stalls on both sides
    ops = 24'($urandom); tag_in = 4'($urandom);
    for (int i = 0; i < 400; i++) begin
      Rin  = 1'($urandom_range(0, 1));
      Aout = ($urandom_range(0, 3) != 0);
      cycle();
      if (in_x) begin ops = 24'($urandom); tag_in = 4'($urandom); end
    end
    Rin = 0; Aout = 1;
    repeat (6) cycle();
    check("rand_drain", q.size(), 0);
    check("rand_balance", n_res, n_in);

    // narrow output instance
    n_ops = {8'd10, 8'd100, 8'd200}; n_tag = 4'd3; n_Rin = 1; n_Aout = 1;
    lat = 0;
    while (!n_Ain && lat < 10) begin @(posedge clk); #1; lat++; end
    @(posedge clk); #1;
    n_Rin = 0;
    lat = 1;
    while (!n_Rout && lat < 10) begin @(posedge clk); #1; lat++; end
    model_res(310, 8, eo, eovf);
    check("narrow_latency", lat, 2);
    check("narrow_out", n_out, eo);
    check("narrow_ovf", n_ovf, eovf);
    check("narrow_tag", n_tago, 3);

    // five-operand instance: three levels
    f_ops = {5{4'hF}}; f_tag = 4'd11; f_Rin = 1; f_Aout = 1;
    lat = 0;
    while (!f_Ain && lat < 10) begin @(posedge clk); #1; lat++; end
    @(posedge clk); #1;
    f_Rin = 0;
    lat = 1;
    while (!f_Rout && lat < 10) begin @(posedge clk); #1; lat++; end
    check("five_latency", lat, 3);
    check("five_out", f_out, sum_ops(64'(f_ops), 5, 4));
    check("five_ovf", f_ovf, 0);
    check("five_tag", f_tago, 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
